// File: rtl/freq_corr_ctrl.sv
// freq_corr_ctrl: steps the LO tuning word from windowed freq_correction votes and declares lock
module freq_corr_ctrl #(
  parameter int TUNE_W      = 16,
  parameter int TUNE_INIT   = 16'h8000,
  parameter int WIN_LEN     = 64,
  parameter int VOTE_TH     = 16,
  parameter int COARSE_STEP = 16,
  parameter int FINE_STEP   = 1,
  parameter int SETTLE_CYC  = 32,
  parameter int LOCK_WIN    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              sample_valid,
  input  logic [1:0]        freq_mod,
  output logic              corr_en,
  output logic [TUNE_W-1:0] tune_word,
  output logic              tune_valid,
  output logic              locked,
  output logic              at_limit,
  output logic              busy
);
  localparam int CW = $clog2(WIN_LEN);
  localparam int VW = CW + 2;
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int QW = $clog2(LOCK_WIN + 1);
  localparam logic signed [VW-1:0] TH = VW'(VOTE_TH);
  typedef enum logic [1:0] {S_IDLE, S_ACQ, S_SETTLE, S_TRACK} state_t;
  state_t                r_state, r_ret;
  logic [CW-1:0]         r_cnt;
  logic signed [VW-1:0]  r_vote;
  logic [SW-1:0]         r_hold;
  logic [QW-1:0]         r_quiet;
  logic [TUNE_W-1:0]     r_tune;
  logic                  r_tv, r_locked;
  logic signed [VW-1:0]  w_inc, w_vote;
  logic                  w_close, w_up, w_dn;
  logic [TUNE_W:0]       w_step, w_sum;
  logic [TUNE_W-1:0]     w_new;
  logic [QW-1:0]         w_q_inc;
  assign w_inc   = (freq_mod == 2'b01) ? VW'(1) : (freq_mod == 2'b10) ? '1 : '0;
  assign w_vote  = r_vote + w_inc;
  assign w_close = sample_valid && (r_cnt == CW'(WIN_LEN - 1));
  assign w_up    = w_vote >= TH;
  assign w_dn    = w_vote <= -TH;
  assign w_step  = (r_state == S_ACQ) ? (TUNE_W+1)'(COARSE_STEP) : (TUNE_W+1)'(FINE_STEP);
  assign w_sum   = w_up ? {1'b0, r_tune} + w_step : {1'b0, r_tune} - w_step;
  assign w_new   = !w_sum[TUNE_W] ? w_sum[TUNE_W-1:0] : w_up ? '1 : '0;
  assign w_q_inc = (r_quiet == QW'(LOCK_WIN)) ? r_quiet : r_quiet + QW'(1);
  assign corr_en    = (r_state == S_ACQ) || (r_state == S_TRACK);
  assign busy       = r_state != S_IDLE;
  assign tune_word  = r_tune;
  assign tune_valid = r_tv;
  assign locked     = r_locked;
  assign at_limit   = (r_tune == '0) || (r_tune == '1);
  // loop sequencing: window accumulation, step/settle, quiet counting and lock
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_ret    <= S_ACQ;
      r_cnt    <= '0;
      r_vote   <= '0;
      r_hold   <= '0;
      r_quiet  <= '0;
      r_tune   <= TUNE_W'(TUNE_INIT);
      r_tv     <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_tv <= 1'b0;
      if (abort) begin
        r_state  <= S_IDLE;
        r_locked <= 1'b0;
      end else if (r_state == S_IDLE) begin
        if (start) begin
          r_state  <= S_ACQ;
          r_cnt    <= '0;
          r_vote   <= '0;
          r_quiet  <= '0;
          r_locked <= 1'b0;
        end
      end else if (r_state == S_SETTLE) begin
        if (r_hold == '0) begin
          r_state <= r_ret;
          r_cnt   <= '0;
          r_vote  <= '0;
        end else begin
          r_hold <= r_hold - SW'(1);
        end
      end else if (sample_valid) begin
        r_cnt  <= w_close ? '0 : r_cnt + CW'(1);
        r_vote <= w_close ? '0 : w_vote;
        if (w_close && (w_up || w_dn)) begin
          r_tune   <= w_new;
          r_tv     <= w_new != r_tune;
          r_ret    <= r_state;
          r_hold   <= SW'(SETTLE_CYC - 1);
          r_state  <= S_SETTLE;
          r_quiet  <= '0;
          r_locked <= 1'b0;
        end else if (w_close && r_state == S_ACQ) begin
          r_state <= S_TRACK;
        end else if (w_close) begin
          r_quiet  <= w_q_inc;
          r_locked <= w_q_inc == QW'(LOCK_WIN);
        end
      end
    end
  end
endmodule

// File: tb/tb_freq_corr_ctrl.sv
// tb_freq_corr_ctrl: randomized stimulus against a window-level reference model of the loop controller
module tb_freq_corr_ctrl;
  localparam int TI = 128, WL = 8, TH = 4, CS = 16, FS = 1, SC = 4, LW = 2, TMAX = 255;
  logic clk = 1'b0;
  logic reset, start, abort, sample_valid;
  logic [1:0] freq_mod;
  logic corr_en, tune_valid, locked, at_limit, busy;
  logic [7:0] tune_word;
  always #5 clk = ~clk;
  freq_corr_ctrl #(
    .TUNE_W(8), .TUNE_INIT(TI), .WIN_LEN(WL), .VOTE_TH(TH), .COARSE_STEP(CS),
    .FINE_STEP(FS), .SETTLE_CYC(SC), .LOCK_WIN(LW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .sample_valid(sample_valid),
    .freq_mod(freq_mod), .corr_en(corr_en), .tune_word(tune_word), .tune_valid(tune_valid),
    .locked(locked), .at_limit(at_limit), .busy(busy)
  );
  typedef enum int {M_IDLE, M_ACQ, M_SETTLE, M_TRACK} mode_e;
  mode_e m_mode = M_IDLE, m_back = M_ACQ;
  int m_hold = 0, m_quiet = 0, m_tune = TI;
  bit m_locked = 0, m_tv = 0, chk_en = 0;
  int m_win[$];
  int n_cmp = 0, n_bad = 0;
  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int clamp(int v);
    return v < 0 ? 0 : (v > TMAX ? TMAX : v);
  endfunction
  task automatic model_step();
    int s, nt;
    m_tv = 0;
    if (reset) begin
      m_mode = M_IDLE; m_tune = TI; m_locked = 0; m_quiet = 0; m_hold = 0; m_win.delete();
    end else if (abort) begin
      m_mode = M_IDLE; m_locked = 0;
    end else if (m_mode == M_IDLE) begin
      if (start) begin
        m_mode = M_ACQ; m_win.delete(); m_quiet = 0; m_locked = 0;
      end
    end else if (m_mode == M_SETTLE) begin
      m_hold--;
      if (m_hold == 0) begin
        m_mode = m_back; m_win.delete();
      end
    end else if (sample_valid) begin
      m_win.push_back(freq_mod == 2'b01 ? 1 : freq_mod == 2'b10 ? -1 : 0);
      if (m_win.size() == WL) begin
        s = m_win.sum();
        m_win.delete();
        if (s >= TH || s <= -TH) begin
          nt = clamp(m_tune + (s > 0 ? 1 : -1) * (m_mode == M_ACQ ? CS : FS));
          m_tv = (nt != m_tune);
          m_tune = nt;
          m_back = m_mode; m_mode = M_SETTLE; m_hold = SC; m_quiet = 0; m_locked = 0;
        end else if (m_mode == M_ACQ) begin
          m_mode = M_TRACK;
        end else begin
          m_quiet = m_quiet < LW ? m_quiet + 1 : LW;
          m_locked = (m_quiet == LW);
        end
      end
    end
  endtask
  always @(negedge clk) begin
    if (chk_en) begin
      chk("tune_word", int'(tune_word), m_tune);
      chk("corr_en", int'(corr_en), int'(m_mode == M_ACQ || m_mode == M_TRACK));
      chk("busy", int'(busy), int'(m_mode != M_IDLE));
      chk("tune_valid", int'(tune_valid), int'(m_tv));
      chk("locked", int'(locked), int'(m_locked));
      chk("at_limit", int'(at_limit), int'(m_tune == 0 || m_tune == TMAX));
    end
  end
  task automatic cyc(bit st, bit ab, bit sv, logic [1:0] fm);
    @(negedge clk);
    start = st; abort = ab; sample_valid = sv; freq_mod = fm;
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic window(int up, int dn, bit ab_last = 0);
    logic [1:0] c[8];
    logic [1:0] t;
    int j;
    for (int i = 0; i < 8; i++)
      c[i] = i < up ? 2'b01 : i < up + dn ? 2'b10 : ($urandom_range(1) == 1 ? 2'b11 : 2'b00);
    for (int i = 7; i > 0; i--) begin
      j = $urandom_range(i);
      t = c[i]; c[i] = c[j]; c[j] = t;
    end
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(3) == 0) cyc(0, 0, 0, 2'($urandom_range(3)));
      cyc(0, (i == 7) && ab_last, 1, c[i]);
    end
  endtask
  task automatic settle_gap();
    int lows = 0;
    for (int k = 0; k < 6; k++) begin
      if (!corr_en) lows++;
      cyc(0, 0, k < 4 ? 1'($urandom_range(1)) : 1'b0, 2'($urandom_range(3)));
    end
    chk("settle_gap", lows, SC);
  endtask
  initial begin
    int bias;
    logic [1:0] fm;
    reset = 1; start = 0; abort = 0; sample_valid = 0; freq_mod = 0;
    cyc(0, 0, 0, 0);
    chk_en = 1;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    reset = 0;
    chk("rst_tune", int'(tune_word), 128);
    chk("rst_busy", int'(busy), 0);
    chk("rst_corr_en", int'(corr_en), 0);
    chk("rst_locked", int'(locked), 0);
    repeat (10) cyc(0, 0, 1'($urandom_range(1)), 2'($urandom_range(3)));
    chk("idle_tune", int'(tune_word), 128);
    cyc(1, 0, 0, 0);
    chk("start_busy", int'(busy), 1);
    chk("start_corr_en", int'(corr_en), 1);
    window(8, 0);
    chk("acq_step_tune", int'(tune_word), 144);
    chk("acq_step_tv", int'(tune_valid), 1);
    settle_gap();
    window(4, 4);
    chk("quiet_no_gap", int'(corr_en), 1);
    window(0, 8);
    chk("track_step_tune", int'(tune_word), 143);
    settle_gap();
    window(0, 0);
    chk("lock_pending", int'(locked), 0);
    window(0, 0);
    chk("locked_set", int'(locked), 1);
    window(0, 5);
    chk("unlock_tune", int'(tune_word), 142);
    chk("unlock_locked", int'(locked), 0);
    settle_gap();
    cyc(0, 1, 0, 0);
    chk("abort_idle", int'(busy), 0);
    cyc(1, 0, 0, 0);
    for (int n = 0; n < 20 && m_tune < TMAX; n++) begin
      window(8, 0);
      settle_gap();
    end
    chk("sat_tune", int'(tune_word), 255);
    chk("sat_at_limit", int'(at_limit), 1);
    window(8, 0);
    chk("sat_no_tv", int'(tune_valid), 0);
    chk("sat_settle", int'(corr_en), 0);
    chk("sat_hold", int'(tune_word), 255);
    settle_gap();
    for (int n = 0; n < 20 && m_tune > 0; n++) begin
      window(0, 8);
      settle_gap();
    end
    chk("floor_tune", int'(tune_word), 0);
    chk("floor_at_limit", int'(at_limit), 1);
    window(0, 8);
    chk("floor_no_tv", int'(tune_valid), 0);
    settle_gap();
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    chk("abort_beats_start", int'(busy), 0);
    cyc(0, 0, 0, 0);
    chk("still_idle", int'(busy), 0);
    cyc(1, 0, 0, 0);
    window(8, 0, 1);
    chk("abort_close_tune", int'(tune_word), 0);
    chk("abort_close_busy", int'(busy), 0);
    chk("abort_close_tv", int'(tune_valid), 0);
    cyc(1, 0, 0, 0);
    window(8, 0);
    chk("pre_reset_tune", int'(tune_word), 16);
    cyc(0, 0, 1, 2'b01);
    reset = 1;
    cyc(0, 0, 1, 2'b01);
    reset = 0;
    chk("settle_rst_tune", int'(tune_word), 128);
    chk("settle_rst_corr_en", int'(corr_en), 0);
    chk("settle_rst_busy", int'(busy), 0);
    chk("settle_rst_locked", int'(locked), 0);
    chk("settle_rst_tv", int'(tune_valid), 0);
    cyc(1, 0, 0, 0);
    bias = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 8 == 0) bias = $urandom_range(3);
      fm = 2'($urandom_range(3));
      if (bias == 0 && $urandom_range(3) != 0) fm = 2'b01;
      if (bias == 1 && $urandom_range(3) != 0) fm = 2'b10;
      if (bias == 3 && $urandom_range(3) != 0) fm = 2'b00;
      reset = ($urandom_range(999) == 0);
      cyc($urandom_range(15) == 0, $urandom_range(299) == 0, $urandom_range(3) != 0, fm);
    end
    reset = 0;
    cyc(0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/freq_corr_ctrl.md
# freq_corr_ctrl

Loop controller that sequences the `freq_correction` block. It enables the corrector, collects its per-sample `freq_mod` direction votes over fixed windows, and turns each window's net vote into a step of the receiver's LO tuning word. After every retune it holds the corrector off while the front end settles, then declares lock once enough consecutive windows show no net offset. It sits between `freq_correction` and the synthesizer/NCO tuning register.

## Interface
Parameters:
- `TUNE_W`, 16, tuning word width (unsigned)
- `TUNE_INIT`, 16'h8000, tuning word after reset
- `WIN_LEN`, 64, valid samples per vote window (≥2)
- `VOTE_TH`, 16, |net vote| needed to step (1..WIN_LEN)
- `COARSE_STEP`, 16, step size in ACQ
- `FINE_STEP`, 1, step size in TRACK
- `SETTLE_CYC`, 32, hold-off cycles after a step (≥1)
- `LOCK_WIN`, 4, consecutive quiet TRACK windows needed for lock

Ports:
- `clk` in 1: single clock, all logic on its rising edge
- `reset` in 1: synchronous, active-high
- `start` in 1: one-cycle request to begin acquisition
- `abort` in 1: return to IDLE
- `sample_valid` in 1: qualifies `freq_mod` (one corrector decision)
- `freq_mod` in 2: 2'b01 = raise frequency, 2'b10 = lower, 2'b00/2'b11 = no vote
- `corr_en` out 1: enable to `freq_correction`
- `tune_word` out TUNE_W: registered LO tuning word
- `tune_valid` out 1: one-cycle pulse when `tune_word` changes
- `locked` out 1: loop locked
- `at_limit` out 1: `tune_word` is at 0 or 2^TUNE_W−1
- `busy` out 1: state ≠ IDLE

## Operation
- States: IDLE, ACQ, SETTLE, TRACK. SETTLE records its return state (ACQ or TRACK).
- IDLE:
  - `corr_en`=0.
  - `start` → ACQ, clears window counter, vote, quiet count and `locked`.
  - `tune_word` keeps its value; it is not reloaded from `TUNE_INIT`.
- ACQ/TRACK:
  - `corr_en`=1.
  - Each `sample_valid` increments the window counter. The signed vote (width clog2(WIN_LEN)+2) adds +1 for 01 and −1 for 10.
  - The window closes on the WIN_LEN-th valid sample. Decision uses the vote including that sample:
    - vote ≥ VOTE_TH: tune_word += step
    - vote ≤ −VOTE_TH: tune_word −= step
    - otherwise: quiet window
  - Step is COARSE_STEP in ACQ and FINE_STEP in TRACK.
  - Arithmetic is done at TUNE_W+1 bits and saturated to [0, 2^TUNE_W−1].
  - A step decision always goes to SETTLE, even if saturation leaves the value unchanged. `tune_valid` pulses only if the value changed.
  - Quiet window in ACQ → TRACK.
  - Quiet window in TRACK → quiet count +1. Reaching LOCK_WIN sets `locked`=1; the count saturates there.
  - A step in TRACK clears `locked` and the quiet count. A step in ACQ leaves both cleared.
  - Window counter and vote clear at every window close and on every entry to ACQ/TRACK.
- SETTLE:
  - `corr_en`=0 for exactly SETTLE_CYC cycles. `sample_valid` is ignored.
  - Then return to the recorded state. `locked` stays 0 throughout.
- `abort` (any state): → IDLE next cycle, `corr_en`=0, `locked`=0, `tune_word` held.
- Simultaneous events:
  - `abort` and `start` together: `abort` wins.
  - `start` while busy: ignored.
  - `abort` on a window-closing cycle: no step is applied.
- `at_limit` is combinational from `tune_word`.

## Timing
- Reset values: state IDLE, `tune_word`=TUNE_INIT, `corr_en`=0, `tune_valid`=0, `locked`=0, `busy`=0. All counters zero.
- `start` sampled at edge N: state ACQ, `busy`=1 and `corr_en`=1 at N+1.
- Window close at edge N (WIN_LEN-th valid sample), step case:
  - `tune_word` updated and `tune_valid`=1 at N+1.
  - `corr_en`=0 during cycles N+1 … N+SETTLE_CYC.
  - `corr_en`=1 again at N+SETTLE_CYC+1.
- Window close, quiet case: next state and `locked` update at N+1. `corr_en` stays 1, no gap.
- `reset` mid-operation overrides everything, including pending steps and `abort`.

## Test plan
Bench parameters: TUNE_W=8, TUNE_INIT=128, WIN_LEN=8, VOTE_TH=4, COARSE_STEP=16, FINE_STEP=1, SETTLE_CYC=4, LOCK_WIN=2.

- Reset then idle 10 cycles:
  - `tune_word`=128, `corr_en`=0, `busy`=0, `tune_valid` never pulses.
- `start`, then 8 valid samples of 01:
  - `tune_word`=144 with one `tune_valid` pulse.
  - `corr_en` low exactly 4 cycles, then back in ACQ.
- From ACQ, 8 samples alternating 01/10:
  - Goes to TRACK.
  - Then 8×10 → `tune_word` decrements by 1 and SETTLE runs.
  - Then two windows of 00 → `locked`=1 one cycle after the second close.
- Locked, then window with vote −5 (5×10, 3×00):
  - `locked`=0 at the cycle `tune_word` decrements.
- TUNE_INIT=250 in ACQ, 8×01:
  - `tune_word`=255, `at_limit`=1.
  - A further 8×01 → SETTLE entered, no `tune_valid`, value stays 255.
- Edge cases:
  - `abort` with `start` in IDLE: stays IDLE.
  - `abort` on a closing cycle: `tune_word` unchanged, IDLE next cycle.
  - `reset` during SETTLE: all outputs return to reset values next cycle.
